// File: rtl/ring_fifo_pkg.sv
// Shared sizing helpers, pointer wrap and parameter legality check for the
// threshold ring FIFO.
package ring_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_RW   = 2'b11
  } fifo_op_e;

  function automatic int ptr_w(input int depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap so non-power-of-two depths use every entry.
  function automatic int unsigned next_ptr(input int unsigned ptr,
                                           input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  function automatic bit params_ok(input int depth, input int afull_lvl,
                                   input int aempty_lvl);
    return (depth >= 2) &&
           (afull_lvl >= 1) && (afull_lvl <= depth) &&
           (aempty_lvl >= 0) && (aempty_lvl <= depth - 1);
  endfunction

endpackage

// File: rtl/ring_fifo_mem.sv
// Storage array for the ring FIFO: synchronous write, asynchronous read.
module ring_fifo_mem
  import ring_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_W     = ptr_w(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_W-1:0]     raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ring_fifo_thr.sv
// FWFT ring FIFO with occupancy count and almost-full/almost-empty levels.
// Define RING_FIFO_ERR_EN to enable the sticky overflow/underflow flags.
module ring_fifo_thr
  import ring_fifo_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int DATA_WIDTH = 8,
  parameter int AFULL_LVL  = 12,
  parameter int AEMPTY_LVL = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         write,
  input  logic [DATA_WIDTH-1:0]        datain,
  input  logic                         read,
  output logic [DATA_WIDTH-1:0]        dataout,
  output logic                         val,
  output logic                         full,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         afull,
  output logic                         aempty,
  input  logic                         clr_err,
  output logic                         overflow,
  output logic                         underflow
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LVL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LVL);

  if (!params_ok(DEPTH, AFULL_LVL, AEMPTY_LVL)) begin : g_bad_params
    $fatal(1, "ring_fifo_thr: illegal DEPTH/AFULL_LVL/AEMPTY_LVL combination");
  end

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt_q;
  logic          wr_en;
  logic          rd_en;
  fifo_op_e      op;

  // Status decodes straight from the count register.
  assign val    = (cnt_q != '0);
  assign full   = (cnt_q == CNT_FULL);
  assign afull  = (cnt_q >= AFULL_C);
  assign aempty = (cnt_q <= AEMPTY_C);
  assign count  = cnt_q;

  // Full blocks writes even with a read pending: no pass-through.
  assign wr_en = write && !full;
  assign rd_en = read && val;
  assign op    = fifo_op_e'({wr_en, rd_en});

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (wr_en) wr_ptr <= PW'(next_ptr(32'(wr_ptr), DEPTH));
      if (rd_en) rd_ptr <= PW'(next_ptr(32'(rd_ptr), DEPTH));
      case (op)
        OP_WR:   cnt_q <= cnt_q + CW'(1);
        OP_RD:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  ring_fifo_mem #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_W     (PW)
  ) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (datain),
    .raddr (rd_ptr),
    .rdata (dataout)
  );

`ifdef RING_FIFO_ERR_EN
  logic ovf_q;
  logic udf_q;

  // A new violation wins over a clear in the same cycle.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (write && full)     ovf_q <= 1'b1;
      else if (clr_err)      ovf_q <= 1'b0;
      if (read && !val)      udf_q <= 1'b1;
      else if (clr_err)      udf_q <= 1'b0;
    end
  end

  assign overflow  = ovf_q;
  assign underflow = udf_q;
`else
  logic unused_clr_err;
  assign unused_clr_err = clr_err;
  assign overflow       = 1'b0;
  assign underflow      = 1'b0;
`endif

endmodule

// File: tb/tb_ring_fifo_thr.sv
// Scoreboard bench for ring_fifo_thr: stimulus queues expected pops, a
// negedge monitor compares every word the DUT hands out.
module tb_ring_fifo_thr;

  localparam int DEPTH = 16;
`ifdef RING_FIFO_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       write = 1'b0;
  logic       read = 1'b0;
  logic       clr_err = 1'b0;
  logic [7:0] datain = '0;
  logic [7:0] dataout;
  logic       val, full, afull, aempty, overflow, underflow;
  logic [4:0] count;

  int checks = 0;
  int failures = 0;

  logic [7:0] mq[$];
  logic [7:0] exp_q[$];
  logic [7:0] mon_e;
  bit         movf = 1'b0;
  bit         mudf = 1'b0;

  always #5 clk = ~clk;

  ring_fifo_thr #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (8),
    .AFULL_LVL  (12),
    .AEMPTY_LVL (4)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .write     (write),
    .datain    (datain),
    .read      (read),
    .dataout   (dataout),
    .val       (val),
    .full      (full),
    .count     (count),
    .afull     (afull),
    .aempty    (aempty),
    .clr_err   (clr_err),
    .overflow  (overflow),
    .underflow (underflow)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must match the next queued word.
  always @(negedge clk) begin
    if (read === 1'b1 && val === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL mon_pop: got dataout %0h expected no pop", dataout);
      end else begin
        mon_e = exp_q.pop_front();
        chk("mon_dataout", {24'h0, dataout}, {24'h0, mon_e});
      end
    end
  end

  task automatic check_status(input string tag);
    int n;
    n = mq.size();
    chk({tag, "_count"},     count,     n);
    chk({tag, "_val"},       val,       (n != 0));
    chk({tag, "_full"},      full,      (n == DEPTH));
    chk({tag, "_afull"},     afull,     (n >= 12));
    chk({tag, "_aempty"},    aempty,    (n <= 4));
    chk({tag, "_overflow"},  overflow,  movf);
    chk({tag, "_underflow"}, underflow, mudf);
  endtask

  task automatic step(input bit w, input logic [7:0] d, input bit r,
                      input bit c, input bit rst, input string tag);
    bit wa, ra;
    reset_n = !rst;
    write   = w;
    datain  = d;
    read    = r;
    clr_err = c;
    if (rst) begin
      if (r && mq.size() > 0) exp_q.push_back(mq[0]);
      mq.delete();
      movf = 1'b0;
      mudf = 1'b0;
    end else begin
      wa = w && (mq.size() < DEPTH);
      ra = r && (mq.size() > 0);
      if (ERR_EN) begin
        if (w && !wa) movf = 1'b1; else if (c) movf = 1'b0;
        if (r && !ra) mudf = 1'b1; else if (c) mudf = 1'b0;
      end
      if (ra) exp_q.push_back(mq.pop_front());
      if (wa) mq.push_back(d);
    end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    write   = 1'b0;
    read    = 1'b0;
    clr_err = 1'b0;
    check_status(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    step(0, 8'h00, 0, 0, 1, "rst");
    step(0, 8'h00, 0, 0, 1, "rst");
    step(0, 8'h00, 0, 0, 0, "idle");
    chk("idle_val", val, 0);
    chk("idle_aempty", aempty, 1);
    chk("idle_count", count, 0);

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1, 8'(i), 0, 0, 0, "fill");
      if (i == 11) chk("afull_at11", afull, 0);
      if (i == 12) chk("afull_at12", afull, 1);
      if (i == 4)  chk("aempty_at4", aempty, 1);
      if (i == 5)  chk("aempty_at5", aempty, 0);
    end
    chk("fill_full", full, 1);
    chk("fill_count", count, 16);

    // Drain in order, then prove pointers wrapped cleanly
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0, "drain");
    chk("drain_val", val, 0);
    step(1, 8'h77, 0, 0, 0, "wrap");
    chk("wrap_head", dataout, 8'h77);
    step(0, 8'h00, 1, 0, 0, "wrap_rd");

    // Streaming read+write at count 8 over several wraps
    for (int i = 0; i < 8; i++) step(1, 8'(8'h30 + i), 0, 0, 0, "pre8");
    for (int i = 0; i < 40; i++) step(1, 8'(8'h40 + i), 1, 0, 0, "rw8");
    chk("rw8_count", count, 8);
    for (int i = 0; i < 8; i++) step(0, 8'h00, 1, 0, 0, "post8");

    // Empty with read+write: only the write lands
    step(1, 8'h5A, 1, 0, 0, "rw_empty");
    chk("rw_empty_count", count, 1);
    chk("rw_empty_head", dataout, 8'h5A);
    step(0, 8'h00, 0, 1, 0, "clr1");

    // Full with read+write: only the read lands
    for (int i = 0; i < 15; i++) step(1, 8'(8'h60 + i), 0, 0, 0, "fill2");
    step(1, 8'hBB, 1, 0, 0, "rw_full");
    chk("rw_full_count", count, 15);
    step(0, 8'h00, 0, 1, 0, "clr2");

    // Overflow: set, set-beats-clear, clear
    step(1, 8'h70, 0, 0, 0, "top");
    step(1, 8'hEE, 0, 0, 0, "ovf");
    chk("ovf_set", overflow, ERR_EN);
    step(1, 8'hEF, 0, 1, 0, "ovf_hold");
    chk("ovf_hold", overflow, ERR_EN);
    step(0, 8'h00, 0, 1, 0, "ovf_clr");
    chk("ovf_clr", overflow, 0);
    for (int i = 0; i < 16; i++) step(0, 8'h00, 1, 0, 0, "drain2");

    // Underflow: set, set-beats-clear, clear
    step(0, 8'h00, 1, 0, 0, "udf");
    chk("udf_set", underflow, ERR_EN);
    step(0, 8'h00, 1, 1, 0, "udf_hold");
    chk("udf_hold", underflow, ERR_EN);
    step(0, 8'h00, 0, 1, 0, "udf_clr");
    chk("udf_clr", underflow, 0);

    // Reset mid-stream at count 9
    for (int i = 0; i < 9; i++) step(1, 8'(8'h90 + i), 0, 0, 0, "pre9");
    step(1, 8'hCC, 1, 0, 1, "rst9");
    chk("rst9_count", count, 0);
    chk("rst9_val", val, 0);
    step(1, 8'hA5, 0, 0, 0, "a5");
    chk("a5_head", dataout, 8'hA5);
    step(0, 8'h00, 1, 0, 0, "a5_rd");

    step(0, 8'h00, 0, 0, 0, "end");
    chk("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ring_fifo_thr.md
# ring_fifo_thr

Parametrised successor to the single-channel ring FIFO. It provides a first-word-fall-through circular buffer that uses all `DEPTH` entries and supports a true simultaneous read and write in one cycle. It also reports occupancy count and programmable almost-full/almost-empty levels. It sits between producer and consumer stages that need level-based flow control rather than just full/valid.

## Interface
Parameters:
- `DEPTH`, 16: number of storage entries; any integer ≥ 2, power of two not required.
- `DATA_WIDTH`, 8: data word width.
- `AFULL_LVL`, 12: `afull` asserts when count ≥ this; legal range 1..DEPTH.
- `AEMPTY_LVL`, 4: `aempty` asserts when count ≤ this; legal range 0..DEPTH-1.

Ports:
- `clk` input 1: single clock, all logic on rising edge.
- `reset_n` input 1: synchronous, active-low reset.
- `write` input 1: write request.
- `datain` input DATA_WIDTH: write data.
- `read` input 1: read request; pops the word currently on `dataout`.
- `dataout` output DATA_WIDTH: head-of-queue word (FWFT); valid only when `val`=1.
- `val` output 1: FIFO non-empty.
- `full` output 1: count == DEPTH.
- `count` output $clog2(DEPTH+1): current occupancy.
- `afull` output 1: almost full.
- `aempty` output 1: almost empty.
- `clr_err` input 1: clears sticky error flags.
- `overflow` output 1: sticky, write attempted while full.
- `underflow` output 1: sticky, read attempted while empty.

## Operation
- Write accepted iff `write` && !`full`. Read accepted iff `read` && `val`.
- Accepted write: store `datain` at `wr_ptr`, advance `wr_ptr`. Accepted read: advance `rd_ptr`.
- Pointers run 0..DEPTH-1 and wrap from DEPTH-1 to 0 explicitly, with no reliance on power-of-two overflow.
- `count` is a register:
  - +1 on write only, -1 on read only.
  - Unchanged when both are accepted or neither is.
- Both accepted in the same cycle (0 < count < DEPTH): both pointers advance and count holds.
- Empty with read+write: read is rejected, write is accepted, count becomes 1.
- Full with read+write: write is rejected (no pass-through), read is accepted, count becomes DEPTH-1.
- `dataout` = mem[`rd_ptr`] combinational. `val` = (count != 0).
- `full`, `afull` and `aempty` decode from the `count` register only.
- Rejected requests have no effect on state other than the error flags.
- Storage contents are not reset. `dataout` is undefined while `val`=0.

## Timing
- Reset: when `reset_n`=0 at an edge, `wr_ptr`, `rd_ptr` and `count` are cleared to 0, and `overflow` and `underflow` to 0. Resulting outputs: `val`=0, `full`=0, `afull`=0, `aempty`=1.
- Reset takes priority over all requests. A reset mid-stream discards all contents the same edge.
- Write latency: a word written at edge N is on `dataout` with `val`=1 after edge N, when the FIFO was empty.
- Read: after the edge that accepts a read, `dataout` shows the next word, or `val`=0 if none remains.
- Status outputs update on the same edge as `count`; there is no extra pipeline stage.

## Configuration
- Macro: `RING_FIFO_ERR_EN`.
- Defined:
  - `overflow` sets on `write` && `full`.
  - `underflow` sets on `read` && !`val`.
  - Both are sticky until a cycle with `clr_err`=1.
  - Set beats clear in the same cycle.
- Undefined: `overflow` and `underflow` are tied to 0, and `clr_err` is ignored. Ports remain present.

## Structure
- Package `ring_fifo_pkg` holds:
  - Pointer-width and count-width helper functions, derived from `DEPTH`.
  - A `next_ptr(ptr, depth)` wrap function.
  - An elaboration parameter-legality check: a fatal error on DEPTH < 2 or thresholds out of range.
- Sub-module `ring_fifo_mem` holds the storage array, with a synchronous write port and an asynchronous read port. Pointer, count and flag logic stays in `ring_fifo_thr`.

## Test plan
- Reset, then idle: `val`=0, `full`=0, `count`=0, `aempty`=1, `afull`=0, errors 0.
- Fill, DEPTH=16, with 0x01..0x10: `full`=1 and `count`=16 after 16th write. `afull` rises after the 12th write. `aempty` falls after the 5th write.
- Drain the full FIFO: data out in order 0x01..0x10, `val`=0 after 16th read, pointers wrapped.
- Simultaneous read+write at count=8 for 40 cycles: count stays 8 and data order is preserved across multiple wraps. At count=0, only the write is taken (count→1). At count=16, only the read is taken (count→15).
- Errors (ERR_EN): write while full sets `overflow` and contents are unchanged. Read while empty sets `underflow`. `clr_err`+new violation in the same cycle keeps the flag at 1. `clr_err` alone clears it.
- Reset asserted at count=9 during read+write: next cycle `count`=0, `val`=0. A following write of 0xA5 appears on `dataout` one cycle later.
